// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch (I) and memory-stage (D) requesters; optional starvation guard via ARB_STARVE_GUARD_EN
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  output logic [DW-1:0] IRData,
  output logic          IStall,
  input  logic          DReq,
  input  logic          DWe,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWData,
  output logic [DW-1:0] DRData,
  output logic          DStall,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  input  logic          MemReady
);
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;
  state_t state, next;
  logic grant_i;
`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STREAK_MAX + 1);
  logic [SW-1:0] streak;
  assign grant_i = IReq & (~DReq | (streak == SW'(STREAK_MAX)));
  // count D grants taken over a waiting fetch; an I grant clears the streak
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) streak <= '0;
    else if (state == IDLE && grant_i) streak <= '0;
    else if (state == IDLE && DReq && IReq) streak <= streak + 1'b1;
`else
  assign grant_i = IReq & ~DReq;
`endif
  // state register
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= next;
  // next-state: D wins in IDLE unless the fetch is granted; busy holds until memory is ready
  always_comb begin
    next = state;
    case (state)
      IDLE:   next = grant_i ? BUSY_I : DReq ? BUSY_D : IDLE;
      BUSY_I: next = MemReady ? DONE_I : BUSY_I;
      BUSY_D: next = MemReady ? DONE_D : BUSY_D;
      default: next = IDLE;
    endcase
  end
  // read buffers capture memory data on completion; stores leave DRData untouched
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      IRData <= '0;
      DRData <= '0;
    end else begin
      if (state == BUSY_I && MemReady) IRData <= MemRData;
      if (state == BUSY_D && MemReady && !DWe) DRData <= MemRData;
    end
  assign MemReq   = (state == BUSY_I) | (state == BUSY_D);
  assign MemWe    = (state == BUSY_D) & DWe;
  assign MemAddr  = (state == BUSY_I) ? IAddr : (state == BUSY_D) ? DAddr : '0;
  assign MemWData = (state == BUSY_D) ? DWData : '0;
  assign IStall   = IReq & (state != DONE_I);
  assign DStall   = DReq & (state != DONE_D);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and randomized model check for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int SM = 2;
  localparam logic [31:0] A  = 32'h2402000A;
  localparam logic [31:0] D1 = 32'h11110040;
  localparam logic [31:0] I2 = 32'h22220200;
  logic CLK = 1'b0, Reset = 1'b1;
  logic IReq = 1'b0, DReq = 1'b0, DWe = 1'b0, MemReady = 1'b0;
  logic [31:0] IAddr = '0, DAddr = '0, DWData = '0, MemRData = '0;
  logic [31:0] IRData, DRData, MemAddr, MemWData;
  logic IStall, DStall, MemReq, MemWe;
  int tests = 0, fails = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .STREAK_MAX(SM)) dut (
    .CLK(CLK), .Reset(Reset),
    .IReq(IReq), .IAddr(IAddr), .IRData(IRData), .IStall(IStall),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DRData(DRData), .DStall(DStall),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemReady(MemReady)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic ireq, dreq, dwe, rdy;
    logic [31:0] ia, da, wd, rd;
    logic mreq, mwe;
    logic [31:0] maddr, mwd;
    logic ist, dst;
    logic [31:0] ird, drd;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // reference model: current owner of the memory (0 none, 1 I, 2 D) and which side is being released
  int m_own, m_done, m_streak;
  logic [31:0] m_ird, m_drd;
  logic i_fin, d_fin, iq, dq, pick_i;
  logic e_ist, e_dst;
  string order, want;
  int grants;
  logic ist_dropped;

  initial begin
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b1, 32'h100,32'h0,32'h0,A,   1'b0,1'b0,32'h0,32'h0,   1'b1,1'b0, 32'h0,32'h0};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b1, 32'h100,32'h0,32'h0,A,   1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0, 32'h0,32'h0};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b1, 32'h100,32'h0,32'h0,A,   1'b0,1'b0,32'h0,32'h0,   1'b0,1'b0, A,32'h0};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,   1'b0,1'b0, A,32'h0};
    tbl[4]  = '{1'b1,1'b1,1'b0,1'b1, 32'h200,32'h40,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1, A,32'h0};
    tbl[5]  = '{1'b1,1'b1,1'b0,1'b1, 32'h200,32'h40,32'h0,D1,    1'b1,1'b0,32'h40,32'h0, 1'b1,1'b1, A,32'h0};
    tbl[6]  = '{1'b1,1'b1,1'b0,1'b1, 32'h200,32'h40,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0, A,D1};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b1, 32'h200,32'h40,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0, A,D1};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b1, 32'h200,32'h40,32'h0,I2,    1'b1,1'b0,32'h200,32'h0, 1'b1,1'b0, A,D1};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b1, 32'h200,32'h40,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0, I2,D1};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,    1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0, I2,D1};

    // reset state
    @(negedge CLK); @(negedge CLK);
    #1;
    chk("reset MemReq", MemReq, 0);
    chk("reset IRData", IRData, 0);
    chk("reset DRData", DRData, 0);
    chk("reset stalls", {IStall, DStall}, 0);
    Reset = 1'b0;

    // single fetch, then simultaneous I/D with D first
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      IReq = tbl[i].ireq; DReq = tbl[i].dreq; DWe = tbl[i].dwe; MemReady = tbl[i].rdy;
      IAddr = tbl[i].ia; DAddr = tbl[i].da; DWData = tbl[i].wd; MemRData = tbl[i].rd;
      #1;
      chk($sformatf("row%0d MemReq", i), MemReq, tbl[i].mreq);
      chk($sformatf("row%0d MemWe", i), MemWe, tbl[i].mwe);
      chk($sformatf("row%0d MemAddr", i), MemAddr, tbl[i].maddr);
      chk($sformatf("row%0d MemWData", i), MemWData, tbl[i].mwd);
      chk($sformatf("row%0d IStall", i), IStall, tbl[i].ist);
      chk($sformatf("row%0d DStall", i), DStall, tbl[i].dst);
      chk($sformatf("row%0d IRData", i), IRData, tbl[i].ird);
      chk($sformatf("row%0d DRData", i), DRData, tbl[i].drd);
    end

    // store with three wait states
    @(negedge CLK);
    DReq = 1'b1; DWe = 1'b1; DAddr = 32'h80; DWData = 32'hCAFEF00D; MemReady = 1'b0; MemRData = 32'hDEADBEEF;
    #1;
    chk("store idle MemReq", MemReq, 0);
    chk("store idle DStall", DStall, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      MemReady = (k == 3);
      #1;
      chk($sformatf("store c%0d req/we", k), {MemReq, MemWe}, 2'b11);
      chk($sformatf("store c%0d MemAddr", k), MemAddr, 32'h80);
      chk($sformatf("store c%0d MemWData", k), MemWData, 32'hCAFEF00D);
      chk($sformatf("store c%0d DStall", k), DStall, 1);
    end
    @(negedge CLK);
    #1;
    chk("store done DStall", DStall, 0);
    chk("store done MemReq", MemReq, 0);
    chk("store DRData kept", DRData, D1);
    @(negedge CLK);
    DReq = 1'b0; DWe = 1'b0;

    // reset in the middle of a load
    @(negedge CLK);
    DReq = 1'b1; DAddr = 32'h44; MemReady = 1'b0;
    @(negedge CLK);
    #1;
    chk("abort busy MemReq", MemReq, 1);
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    chk("abort MemReq", MemReq, 0);
    chk("abort DStall", DStall, 1);
    chk("abort buffers", {IRData, DRData}, 0);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    chk("after abort idle", MemReq, 0);
    @(negedge CLK);
    MemReady = 1'b1; MemRData = 32'h5555;
    #1;
    chk("fresh access MemReq", MemReq, 1);
    chk("fresh access MemAddr", MemAddr, 32'h44);
    @(negedge CLK);
    #1;
    chk("fresh done DStall", DStall, 0);
    chk("fresh done DRData", DRData, 32'h5555);
    @(negedge CLK);
    DReq = 1'b0;

    // arbitration order with both sides asking continuously
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    IReq = 1'b1; DReq = 1'b1; DWe = 1'b0; IAddr = 32'h300; DAddr = 32'h400; MemReady = 1'b1;
    order = ""; grants = 0; ist_dropped = 1'b0;
    for (int c = 0; c < 60 && grants < 6; c++) begin
      @(negedge CLK);
      #1;
      if (!IStall) ist_dropped = 1'b1;
      if (MemReq) begin
        order = {order, (MemAddr == 32'h300) ? "I" : "D"};
        grants++;
      end
    end
`ifdef ARB_STARVE_GUARD_EN
    want = "DDIDDI";
`else
    want = "DDDDDD";
    chk("IStall held high", ist_dropped, 0);
`endif
    tests++;
    if (order != want) begin
      fails++;
      $display("FAIL grant order: got %s expected %s", order, want);
    end
    @(negedge CLK);
    IReq = 1'b0; DReq = 1'b0;

    // randomized traffic against the reference model
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    m_own = 0; m_done = 0; m_streak = 0; m_ird = '0; m_drd = '0;
    iq = 1'b0; dq = 1'b0; i_fin = 1'b0; d_fin = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      if (!iq || i_fin) begin iq = 1'($urandom); IAddr = $urandom; end
      if (!dq || d_fin) begin dq = 1'($urandom); DAddr = $urandom; DWe = 1'($urandom); DWData = $urandom; end
      IReq = iq; DReq = dq;
      MemReady = ($urandom % 3) != 0;
      MemRData = $urandom;
      #1;
      e_ist = IReq && m_done != 1;
      e_dst = DReq && m_done != 2;
      chk($sformatf("rnd%0d MemReq", c), MemReq, m_own != 0);
      chk($sformatf("rnd%0d MemWe", c), MemWe, m_own == 2 && DWe);
      chk($sformatf("rnd%0d MemAddr", c), MemAddr, m_own == 1 ? IAddr : m_own == 2 ? DAddr : 32'h0);
      chk($sformatf("rnd%0d MemWData", c), MemWData, m_own == 2 ? DWData : 32'h0);
      chk($sformatf("rnd%0d IStall", c), IStall, e_ist);
      chk($sformatf("rnd%0d DStall", c), DStall, e_dst);
      chk($sformatf("rnd%0d IRData", c), IRData, m_ird);
      chk($sformatf("rnd%0d DRData", c), DRData, m_drd);
      i_fin = iq && !e_ist;
      d_fin = dq && !e_dst;
      if (m_own != 0) begin
        if (MemReady) begin
          if (m_own == 1) m_ird = MemRData;
          else if (!DWe) m_drd = MemRData;
          m_done = m_own;
          m_own = 0;
        end
      end else if (m_done != 0) begin
        m_done = 0;
      end else begin
`ifdef ARB_STARVE_GUARD_EN
        pick_i = IReq && (!DReq || m_streak == SM);
`else
        pick_i = IReq && !DReq;
`endif
        if (pick_i) begin
          m_own = 1;
          m_streak = 0;
        end else if (DReq) begin
          m_own = 2;
          if (IReq) m_streak++;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the pipeline's instruction-fetch stage (I side) and memory stage (D side).
- Sequences each access through a request/ready handshake with the memory.
- Drives per-side stall signals so the pipeline holds while an access is outstanding.
- Sits between the pipeline datapath/hazard logic and the external memory model.

Parameters:
AW, 32, address width
DW, 32, data width
STREAK_MAX, 4, consecutive D grants allowed while I is waiting (ARB_STARVE_GUARD_EN only)

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
IReq  in  1  fetch wants a read; held until IStall low
IAddr  in  AW  fetch address; stable while IReq high
IRData  out  DW  fetch read data; valid while state DONE_I
IStall  out  1  stall fetch stage
DReq  in  1  load/store wants access; held until DStall low
DWe  in  1  1 = store, 0 = load
DAddr  in  AW  data address
DWData  in  DW  store data
DRData  out  DW  load data; valid while state DONE_D
DStall  out  1  stall memory stage
MemReq  out  1  access request to memory
MemWe  out  1  write enable to memory
MemAddr  out  AW  memory address
MemWData  out  DW  memory write data
MemRData  in  DW  memory read data, valid with MemReady
MemReady  in  1  memory completes current access this cycle

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D. Reset value is IDLE.
- IDLE transitions:
  - DReq -> BUSY_D, since data has priority as the older instruction.
  - else IReq -> BUSY_I.
  - else stay in IDLE.
- BUSY_x:
  - MemReq=1, driven combinationally from the owner's inputs.
  - MemAddr is the owner's address.
  - MemWe = DWe in BUSY_D, 0 in BUSY_I.
  - MemWData = DWData in BUSY_D, 0 otherwise.
  - Holds until MemReady=1, then latches MemRData into the owner's read buffer and moves to DONE_x.
- DONE_x:
  - Owner's stall is 0 for exactly one cycle; that side's read data is valid that cycle.
  - Next state is always IDLE.
  - A still-high request in DONE_x is treated as the old one; a new request is sampled in IDLE.
- Stalls:
  - IStall = IReq & (state != DONE_I).
  - DStall = DReq & (state != DONE_D).
  - A side with no request never stalls.
- Minimum latency for a zero-wait memory: request in cycle 0, MemReq in cycle 1, DONE in cycle 2. Three cycles per access; one idle cycle between back-to-back accesses.
- Stores also go through DONE_D; the DRData buffer is not updated on a store.
- Outside BUSY states, MemReq, MemWe, MemAddr and MemWData are all 0.
- IRData and DRData hold their last latched value; both reset to 0.
- MemReady outside BUSY states is ignored.
- If a requester drops its request in BUSY (illegal), the access still completes and the FSM returns to IDLE via DONE.
- Reset asserted mid-access:
  - Immediately forces IDLE, MemReq=0 and both read buffers to 0.
  - Stalls then follow their requests.
  - The aborted memory access is not retried.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - A $clog2(STREAK_MAX+1)-bit streak counter increments on each IDLE->BUSY_D transition taken while IReq=1.
  - It clears on any IDLE->BUSY_I transition and on reset.
  - When the counter equals STREAK_MAX and IReq=1 in IDLE, I is granted even if DReq=1.
- Undefined: fixed D-over-I priority, no counter logic.

Test Plan:
- Reset, then IReq=1, IAddr=0x100, MemReady tied 1, MemRData=0x2402000A -> MemReq high in cycle 1 only, IStall low in cycle 2, IRData=0x2402000A, state IDLE in cycle 3.
- IReq and DReq rise in the same cycle, DWe=0, DAddr=0x40, MemReady=1 -> first MemAddr=0x40, DStall released in cycle 2; then MemAddr=IAddr in cycle 4, IStall released in cycle 5.
- Store DWe=1, DAddr=0x80, DWData=0xCAFEF00D, MemReady low for 3 cycles -> MemReq=MemWe=1 with those values for 4 cycles, DStall high until DONE_D, DRData unchanged.
- Reset pulsed while in BUSY_D with MemReady=0 -> MemReq and DStall's grant drop immediately; after reset release with DReq still high, a fresh access starts from IDLE.
- ARB_STARVE_GUARD_EN with STREAK_MAX=2, DReq and IReq both held high (D re-requesting each IDLE) -> grant order D, D, I, D, D, I.
- Without the macro, the same stimulus -> D granted every time and IStall stays high.
